// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: special instruction words, opcodes and IF FSM encoding.
package mips_pkg;

  localparam int unsigned NB_DATA = 32;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } if_state_e;

  // Sequential PC step; wraps silently at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: one synchronous write port for program load, one asynchronous read port.
module instruction_memory #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned IMEM_ADDR_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [IMEM_ADDR_W-1:0] i_waddr,
  input  logic [NB_DATA-1:0]     i_wdata,
  input  logic [IMEM_ADDR_W-1:0] i_raddr,
  output logic [NB_DATA-1:0]     o_rdata
);

  logic [NB_DATA-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // A same-edge write is not yet visible here, so a concurrent fetch sees the old word.
  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, next-PC mux, RUN/HALT FSM and IF/ID register.
// Optional macro IF_BRANCH_FLUSH_EN squashes the delay-slot word on a taken jump.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned IMEM_ADDR_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [NB_DATA-1:0]     i_jump_addr,
  input  logic                   i_imem_we,
  input  logic [IMEM_ADDR_W-1:0] i_imem_waddr,
  input  logic [NB_DATA-1:0]     i_imem_wdata,
  output logic [NB_DATA-1:0]     o_pc,
  output logic [NB_DATA-1:0]     o_pc4,
  output logic [NB_DATA-1:0]     o_instruction,
  output logic                   o_halt
);

  localparam logic [NB_DATA-1:0] PC_STEP = NB_DATA'(4);
  localparam logic [NB_DATA-1:0] NOP_W   = NB_DATA'(NOP_INSTR);
  localparam logic [NB_DATA-1:0] HALT_W  = NB_DATA'(HALT_INSTR);

  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  if_state_e          state_q, state_d;

  logic [NB_DATA-1:0] fetch_word;
  logic [NB_DATA-1:0] pc_seq;
  logic               adv;

  instruction_memory #(
    .NB_DATA     (NB_DATA),
    .IMEM_DEPTH  (IMEM_DEPTH),
    .IMEM_ADDR_W (IMEM_ADDR_W)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (i_imem_we),
    .i_waddr (i_imem_waddr),
    .i_wdata (i_imem_wdata),
    .i_raddr (pc_q[IMEM_ADDR_W+1:2]),
    .o_rdata (fetch_word)
  );

  assign pc_seq = pc_q + PC_STEP;
  assign adv    = i_enable & ~i_stall & (state_q == ST_RUN);

  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    state_d = state_q;
    if (state_q == ST_HALT) begin
      // The HALT word drains downstream once, then NOPs forever.
      pc4_d   = pc_seq;
      instr_d = NOP_W;
    end else if (adv) begin
      pc4_d   = pc_seq;
      instr_d = fetch_word;
      if (fetch_word == HALT_W) begin
        state_d = ST_HALT;
      end else begin
        pc_d = i_jump ? i_jump_addr : pc_seq;
`ifdef IF_BRANCH_FLUSH_EN
        if (i_jump) instr_d = NOP_W;
`endif
      end
    end
  end

  // Stage boundary: PC / FSM / IF-ID register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_W;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      state_q <= state_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc4         = pc4_q;
  assign o_instruction = instr_q;
  assign o_halt        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_instruction_fetch;

`ifdef IF_BRANCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, stall = 1'b0, jump = 1'b0, we = 1'b0;
  logic [31:0] jaddr = '0, wdata = '0;
  logic [7:0]  waddr = '0;
  logic [31:0] o_pc, o_pc4, o_instr;
  logic        o_halt;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_pc4, m_instr;
  bit          m_halted;
  bit          chk_en = 1'b0;

  instruction_fetch dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_stall       (stall),
    .i_jump        (jump),
    .i_jump_addr   (jaddr),
    .i_imem_we     (we),
    .i_imem_waddr  (waddr),
    .i_imem_wdata  (wdata),
    .o_pc          (o_pc),
    .o_pc4         (o_pc4),
    .o_instruction (o_instr),
    .o_halt        (o_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_halted = 0;
  endtask

  // Model: fetch uses the word before any same-edge write lands.
  always @(posedge clk) begin
    if (rst_n) begin
      logic [31:0] w;
      w = m_mem[m_pc[9:2]];
      if (m_halted) begin
        m_pc4 = m_pc + 4; m_instr = 0;
      end else if (en && !stall) begin
        m_pc4 = m_pc + 4;
        if (w == 32'hFFFF_FFFF) begin
          m_instr = w; m_halted = 1;
        end else begin
          m_instr = (FLUSH && jump) ? 32'h0 : w;
          m_pc    = jump ? jaddr : m_pc + 4;
        end
      end
    end
    if (we) m_mem[waddr] = wdata;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", o_pc, m_pc);
      check("pc4", o_pc4, m_pc4);
      check("instr", o_instr, m_instr);
      check("halt", {31'b0, o_halt}, {31'b0, m_halted});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pc", o_pc, 32'h0);
    check("rst_pc4", o_pc4, 32'h0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_halt", {31'b0, o_halt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  localparam logic [31:0] WA = 32'h2001_0001, WB = 32'h2002_0002, WC = 32'h2003_0003;
  localparam logic [31:0] WD = 32'h2008_0008, WX = 32'h3C0F_BEEF;

  initial begin
    logic [31:0] r;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      if (r == 32'hFFFF_FFFF) r = 32'h1;
      load(8'(i), r);
    end
    load(8'd0, WA); load(8'd1, WB); load(8'd2, WC); load(8'd8, WD);

    // Sequential fetch
    en = 1;
    tick(); check("t1_i0", o_instr, WA); check("t1_p0", o_pc4, 32'd4);
    tick(); check("t1_i1", o_instr, WB); check("t1_p1", o_pc4, 32'd8);
    tick(); check("t1_i2", o_instr, WC); check("t1_p2", o_pc4, 32'd12);
    check("t1_pc", o_pc, 32'd12);

    // Jump with delay slot
    async_reset();
    tick(); tick();
    check("t2_pc8", o_pc, 32'h8);
    jump = 1; jaddr = 32'h20;
    tick();
    check("t2_slot", o_instr, FLUSH ? 32'h0 : WC);
    check("t2_pc", o_pc, 32'h20);
    jump = 0;
    tick();
    check("t2_tgt", o_instr, WD); check("t2_pc4", o_pc4, 32'h24);

    // Stall overrides jump
    stall = 1; jump = 1; jaddr = 32'h40;
    tick(); tick();
    check("t3_pc", o_pc, 32'h24); check("t3_pc4", o_pc4, 32'h24);
    check("t3_instr", o_instr, WD);
    stall = 0; jump = 0;

    // Same-edge write and fetch returns the old word
    async_reset();
    tick();
    we = 1; waddr = 8'd1; wdata = WX;
    tick();
    we = 0;
    check("t6_old", o_instr, WB);
    jump = 1; jaddr = 32'h4;
    tick();
    jump = 0;
    tick();
    check("t6_new", o_instr, WX);

    // HALT word
    en = 0;
    load(8'd3, 32'hFFFF_FFFF);
    async_reset();
    en = 1;
    tick(); tick(); tick(); tick();
    check("t4_instr", o_instr, 32'hFFFF_FFFF);
    check("t4_halt", {31'b0, o_halt}, 32'h1);
    check("t4_pc", o_pc, 32'hC);
    jump = 1; jaddr = 32'h80; stall = 1;
    tick(); tick();
    check("t4_nop", o_instr, 32'h0); check("t4_pc_hold", o_pc, 32'hC);
    check("t4_pc4", o_pc4, 32'h10);
    jump = 0; stall = 0;
    load(8'd3, 32'h2004_0004);

    // Randomized traffic
    async_reset();
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 4) == 0);
      jump  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       jaddr = $urandom;
        1:       jaddr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: jaddr = {22'b0, 8'($urandom), 2'($urandom)};
      endcase
      we    = ($urandom_range(0, 4) == 0);
      waddr = 8'($urandom);
      wdata = ($urandom_range(0, 199) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 299) == 0) begin
        we = 0;
        async_reset();
      end else begin
        tick();
      end
    end
    we = 0; jump = 0; stall = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
